reset_sequencer: RTL and testbench

Staged reset-release sequencer that sits downstream of the PLL-lock reset generator and consumes its active-low reset output. After that reset deasserts, it releases up to NUM_STAGES subsystem resets one at a time, in index order. Each stage must acknowledge readiness before the next stage is released. Ack timeouts and post-sequence ack loss trigger a full re-assert and retry, bounded by MAX_RETRY, after which the block latches a sticky failure.

---
 rtl/reset_sequencer.sv | 166 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Staged reset-release sequencer: releases per-stage active-low resets in index order,
// each gated by its ack, with timeout/ack-loss retry and a sticky failure after MAX_RETRY aborts.
module reset_sequencer #(
  parameter int unsigned NUM_STAGES       = 4,
  parameter int unsigned STAGE_GAP_CYCLES = 16,
  parameter int unsigned ACK_TIMEOUT      = 255,
  parameter int unsigned MAX_RETRY        = 3,
  localparam int unsigned STAGE_W = $clog2(NUM_STAGES),
  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1)
) (
  input  logic                  clk_In,
  input  logic                  rst_n,
  input  logic [NUM_STAGES-1:0] stage_ack_in,
  output logic [NUM_STAGES-1:0] rst_n_stage_out,
  output logic                  seq_done,
  output logic                  seq_fail,
  output logic [STAGE_W-1:0]    fail_stage,
  output logic [RETRY_W-1:0]    retry_cnt
);

  localparam int unsigned TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int unsigned GAP_W = (STAGE_GAP_CYCLES > 1) ? $clog2(STAGE_GAP_CYCLES) : 1;
  localparam logic [TMR_W-1:0]   TMR_LAST   = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(STAGE_GAP_CYCLES - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(NUM_STAGES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ACK,
    GAP,
    DONE,
    ABORT,
    FAIL
  } state_t;

  state_t                  state_q, state_d;
  logic [STAGE_W-1:0]      k_q, k_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic [NUM_STAGES-1:0]   out_d;
  logic                    done_d, fail_d;
  logic [STAGE_W-1:0]      fstage_d;
  logic [RETRY_W-1:0]      retry_d;
  logic                    abort_c;
  logic [STAGE_W-1:0]      abort_idx_c;
  logic [STAGE_W-1:0]      drop_idx_c;

  // Lowest stage index whose ack is currently low
  always_comb begin
    drop_idx_c = '0;
    for (int i = int'(NUM_STAGES) - 1; i >= 0; i--) begin
      if (!stage_ack_in[i]) drop_idx_c = STAGE_W'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    timer_d     = timer_q;
    gap_d       = gap_q;
    out_d       = rst_n_stage_out;
    done_d      = seq_done;
    fail_d      = seq_fail;
    fstage_d    = fail_stage;
    retry_d     = retry_cnt;
    abort_c     = 1'b0;
    abort_idx_c = '0;

    case (state_q)
      IDLE: begin
        k_d     = '0;
        out_d   = NUM_STAGES'(1);
        timer_d = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (stage_ack_in[k_q]) begin
          if (k_q == STAGE_LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = GAP;
            gap_d   = '0;
          end
        end else if (timer_q == TMR_LAST) begin
          abort_c     = 1'b1;
          abort_idx_c = k_q;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          k_d        = k_q + STAGE_W'(1);
          out_d[k_d] = 1'b1;
          timer_d    = '0;
          state_d    = WAIT_ACK;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      DONE: begin
        if (!(&stage_ack_in)) begin
          abort_c     = 1'b1;
          abort_idx_c = drop_idx_c;
        end
      end
      ABORT: begin
        if (gap_q == GAP_LAST) begin
          if (retry_cnt == RETRY_MAX) begin
            state_d = FAIL;
            fail_d  = 1'b1;
          end else begin
            k_d     = '0;
            out_d   = NUM_STAGES'(1);
            timer_d = '0;
            state_d = WAIT_ACK;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      FAIL: begin
        out_d  = '0;
        fail_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Common abort entry: drop every stage and count the retry
    if (abort_c) begin
      state_d  = ABORT;
      out_d    = '0;
      done_d   = 1'b0;
      fstage_d = abort_idx_c;
      retry_d  = (retry_cnt == RETRY_MAX) ? retry_cnt : retry_cnt + RETRY_W'(1);
      gap_d    = '0;
    end
  end

  always_ff @(posedge clk_In or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      k_q             <= '0;
      timer_q         <= '0;
      gap_q           <= '0;
      rst_n_stage_out <= '0;
      seq_done        <= 1'b0;
      seq_fail        <= 1'b0;
      fail_stage      <= '0;
      retry_cnt       <= '0;
    end else begin
      state_q         <= state_d;
      k_q             <= k_d;
      timer_q         <= timer_d;
      gap_q           <= gap_d;
      rst_n_stage_out <= out_d;
      seq_done        <= done_d;
      seq_fail        <= fail_d;
      fail_stage      <= fstage_d;
      retry_cnt       <= retry_d;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed scenarios plus randomized acks/resets,
// compared every cycle against a counter-based behavioural model.
module tb_reset_sequencer;

  localparam int unsigned NS = 4;
  localparam int unsigned G  = 4;
  localparam int unsigned T  = 8;
  localparam int unsigned MR = 3;
  localparam int unsigned SW = $clog2(NS);
  localparam int unsigned RW = $clog2(MR + 1);

  logic          clk_In = 1'b0;
  logic          rst_n  = 1'b1;
  logic [NS-1:0] stage_ack_in = '0;
  logic [NS-1:0] rst_n_stage_out;
  logic          seq_done;
  logic          seq_fail;
  logic [SW-1:0] fail_stage;
  logic [RW-1:0] retry_cnt;

  int total = 0;
  int bad   = 0;

  // Model state: how many stages are released, and what the sequencer is waiting on
  bit m_started, m_done, m_fail;
  int m_rel, m_wait, m_settle, m_hold, m_fstage, m_retry;

  always #5 clk_In = ~clk_In;

  reset_sequencer #(
    .NUM_STAGES      (NS),
    .STAGE_GAP_CYCLES(G),
    .ACK_TIMEOUT     (T),
    .MAX_RETRY       (MR)
  ) dut (
    .clk_In         (clk_In),
    .rst_n          (rst_n),
    .stage_ack_in   (stage_ack_in),
    .rst_n_stage_out(rst_n_stage_out),
    .seq_done       (seq_done),
    .seq_fail       (seq_fail),
    .fail_stage     (fail_stage),
    .retry_cnt      (retry_cnt)
  );

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_done = 0; m_fail = 0;
    m_rel = 0; m_wait = 0; m_settle = 0; m_hold = 0; m_fstage = 0; m_retry = 0;
  endtask

  task automatic model_abort(input int idx);
    m_rel    = 0;
    m_done   = 0;
    m_fstage = idx;
    m_retry  = (m_retry + 1 > int'(MR)) ? int'(MR) : m_retry + 1;
    m_hold   = G;
  endtask

  // One clock edge of the model, given the ack value sampled at that edge
  task automatic model_step(input logic [NS-1:0] a);
    int low;
    if (!m_started) begin
      m_started = 1; m_rel = 1; m_wait = 0;
    end else if (m_fail) begin
      m_rel = 0;
    end else if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) begin
        if (m_retry == int'(MR)) m_fail = 1;
        else begin m_rel = 1; m_wait = 0; end
      end
    end else if (m_done) begin
      if (a != '1) begin
        low = 0;
        for (int i = int'(NS) - 1; i >= 0; i--) if (!a[i]) low = i;
        model_abort(low);
      end
    end else if (m_settle > 0) begin
      m_settle--;
      if (m_settle == 0) begin m_rel++; m_wait = 0; end
    end else begin
      if (a[m_rel-1]) begin
        if (m_rel == int'(NS)) m_done = 1;
        else m_settle = G;
      end else begin
        m_wait++;
        if (m_wait == int'(T)) model_abort(m_rel - 1);
      end
    end
  endtask

  task automatic check_model(input string tag);
    expect_eq({tag, ".out"},    32'(rst_n_stage_out), 32'((1 << m_rel) - 1));
    expect_eq({tag, ".done"},   32'(seq_done),        32'(m_done));
    expect_eq({tag, ".fail"},   32'(seq_fail),        32'(m_fail));
    expect_eq({tag, ".fstage"}, 32'(fail_stage),      32'(m_fstage));
    expect_eq({tag, ".retry"},  32'(retry_cnt),       32'(m_retry));
  endtask

  task automatic cyc(input int n);
    logic [NS-1:0] a;
    repeat (n) begin
      @(posedge clk_In);
      a = stage_ack_in;
      model_step(a);
      #1;
      check_model("cyc");
    end
  endtask

  // Asserts rst_n between edges, checks the asynchronous clear, releases before the next edge
  task automatic do_reset();
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    expect_eq("rst.out",   32'(rst_n_stage_out), 32'd0);
    expect_eq("rst.done",  32'(seq_done),        32'd0);
    expect_eq("rst.fail",  32'(seq_fail),        32'd0);
    expect_eq("rst.retry", 32'(retry_cnt),       32'd0);
    check_model("rst");
    #1 rst_n = 1'b1;
  endtask

  initial begin
    model_reset();

    // Nominal: acks tied high, stages released every G+1 edges
    stage_ack_in = '1;
    do_reset();
    cyc(1);  expect_eq("nom.e1",  32'(rst_n_stage_out), 32'h1);
    cyc(5);  expect_eq("nom.e6",  32'(rst_n_stage_out), 32'h3);
    cyc(5);  expect_eq("nom.e11", 32'(rst_n_stage_out), 32'h7);
    cyc(5);  expect_eq("nom.e16", 32'(rst_n_stage_out), 32'hf);
             expect_eq("nom.e16d", 32'(seq_done), 32'd0);
    cyc(1);  expect_eq("nom.e17d", 32'(seq_done), 32'd1);
             expect_eq("nom.retry", 32'(retry_cnt), 32'd0);

    // Ack loss in DONE: stages 2 and 3 drop together
    stage_ack_in = 4'b0011;
    cyc(1);
    expect_eq("loss.out",    32'(rst_n_stage_out), 32'h0);
    expect_eq("loss.done",   32'(seq_done),        32'd0);
    expect_eq("loss.fstage", 32'(fail_stage),      32'd2);
    expect_eq("loss.retry",  32'(retry_cnt),       32'd1);
    stage_ack_in = '1;
    cyc(4);  expect_eq("loss.restart", 32'(rst_n_stage_out), 32'h1);
    cyc(16); expect_eq("loss.redone",  32'(seq_done), 32'd1);

    // Timeout on stage 1
    stage_ack_in = 4'b0001;
    do_reset();
    cyc(6);  expect_eq("to.rel1", 32'(rst_n_stage_out), 32'h3);
    cyc(7);  expect_eq("to.pre",  32'(rst_n_stage_out), 32'h3);
    cyc(1);
    expect_eq("to.out",    32'(rst_n_stage_out), 32'h0);
    expect_eq("to.fstage", 32'(fail_stage),      32'd1);
    expect_eq("to.retry",  32'(retry_cnt),       32'd1);
    cyc(3);  expect_eq("to.hold",    32'(rst_n_stage_out), 32'h0);
    cyc(1);  expect_eq("to.restart", 32'(rst_n_stage_out), 32'h1);

    // Ack arrives on the timeout cycle
    stage_ack_in = '0;
    do_reset();
    cyc(T);
    stage_ack_in = 4'b0001;
    cyc(1);
    expect_eq("late.out",   32'(rst_n_stage_out), 32'h1);
    expect_eq("late.retry", 32'(retry_cnt),       32'd0);
    cyc(G);  expect_eq("late.gap", 32'(rst_n_stage_out), 32'h3);

    // Retry exhaustion with stage 0 never acking
    stage_ack_in = '0;
    do_reset();
    cyc(36); expect_eq("ex.prefail", 32'(seq_fail), 32'd0);
    cyc(1);
    expect_eq("ex.fail",  32'(seq_fail),        32'd1);
    expect_eq("ex.out",   32'(rst_n_stage_out), 32'h0);
    expect_eq("ex.retry", 32'(retry_cnt),       32'd3);
    for (int c = 0; c < 1000; c++) begin
      stage_ack_in = NS'($urandom);
      cyc(1);
    end
    expect_eq("ex.stay", 32'(seq_fail), 32'd1);

    // Reset mid-GAP
    stage_ack_in = '1;
    do_reset();
    cyc(3);
    do_reset();
    cyc(1);
    expect_eq("mid.out",   32'(rst_n_stage_out), 32'h1);
    expect_eq("mid.retry", 32'(retry_cnt),       32'd0);

    // Randomized acks with occasional resets
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(99) < 6) stage_ack_in = NS'($urandom);
      else if ($urandom_range(99) < 25) stage_ack_in = '1;
      if ($urandom_range(299) == 0) do_reset();
      cyc(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
